// File: rtl/alu_operand_stage.sv
// ALU operand-select stage: decodes reg-reg / reg-imm / reg-shamt operands
// and issues them through a 2-entry skid buffer with an issued-op counter.
module alu_operand_stage #(
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 22,
  parameter int SHAMT_W  = 5,
  parameter bit IMM_SEXT = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  rs,
  input  logic [DATA_W-1:0]  rt,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [IMM_W-1:0]   immt,
  input  logic [2:0]         opcode,
  input  logic [3:0]         fcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  inp1,
  output logic [DATA_W-1:0]  inp2,
  output logic [1:0]         op_kind,
  output logic [CNT_W-1:0]   alu_op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] or_inp1_q, or_inp1_d;
  logic [DATA_W-1:0] or_inp2_q, or_inp2_d;
  logic [1:0]        or_kind_q, or_kind_d;
  logic [DATA_W-1:0] sr_inp1_q, sr_inp1_d;
  logic [DATA_W-1:0] sr_inp2_q, sr_inp2_d;
  logic [1:0]        sr_kind_q, sr_kind_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] dec_inp1;
  logic [DATA_W-1:0] dec_inp2;
  logic [1:0]        dec_kind;
  logic              fill;
  logic              accept;
  logic              issue;

  // Upper immediate bits are filled bit by bit so DATA_W == IMM_W
  // simply leaves the loop empty.
  always_comb begin
    fill    = IMM_SEXT && immt[IMM_W-1];
    imm_ext = DATA_W'(immt);
    for (int i = IMM_W; i < DATA_W; i++) begin
      imm_ext[i] = fill;
    end
  end

  always_comb begin
    dec_inp1 = '0;
    dec_inp2 = '0;
    dec_kind = 2'd0;
    unique case (1'b1)
      (opcode == 3'd1): begin
        dec_inp1 = rs;
        dec_inp2 = imm_ext;
        dec_kind = 2'd2;
      end
      (opcode == 3'd0 && fcode <= 4'd11): begin
        dec_inp1 = rs;
        dec_inp2 = rt;
        dec_kind = 2'd1;
      end
      (opcode == 3'd0 && fcode >= 4'd12): begin
        dec_inp1 = rs;
        dec_inp2 = DATA_W'(shamt);
        dec_kind = 2'd3;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign issue     = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    or_inp1_d = or_inp1_q;
    or_inp2_d = or_inp2_q;
    or_kind_d = or_kind_q;
    sr_inp1_d = sr_inp1_q;
    sr_inp2_d = sr_inp2_q;
    sr_kind_d = sr_kind_q;
    cnt_d     = cnt_q;
    if (issue && or_kind_q != 2'd0) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          or_inp1_d = dec_inp1;
          or_inp2_d = dec_inp2;
          or_kind_d = dec_kind;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && issue) begin
          or_inp1_d = dec_inp1;
          or_inp2_d = dec_inp2;
          or_kind_d = dec_kind;
        end else if (accept) begin
          sr_inp1_d = dec_inp1;
          sr_inp2_d = dec_inp2;
          sr_kind_d = dec_kind;
          state_d   = TWO;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (issue) begin
          or_inp1_d = sr_inp1_q;
          or_inp2_d = sr_inp2_q;
          or_kind_d = sr_kind_q;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      or_inp1_q <= '0;
      or_inp2_q <= '0;
      or_kind_q <= 2'd0;
      sr_inp1_q <= '0;
      sr_inp2_q <= '0;
      sr_kind_q <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      or_inp1_q <= or_inp1_d;
      or_inp2_q <= or_inp2_d;
      or_kind_q <= or_kind_d;
      sr_inp1_q <= sr_inp1_d;
      sr_inp2_q <= sr_inp2_d;
      sr_kind_q <= sr_kind_d;
      cnt_q     <= cnt_d;
    end
  end

  assign inp1         = or_inp1_q;
  assign inp2         = or_inp2_q;
  assign op_kind      = or_kind_q;
  assign alu_op_count = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a sign-extending and a
// zero-extending/2-bit-counter instance share one stimulus stream.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [4:0]  shamt;
  logic [21:0] immt;
  logic [2:0]  opcode;
  logic [3:0]  fcode;

  logic        in_ready_a, out_valid_a;
  logic [31:0] inp1_a, inp2_a;
  logic [1:0]  kind_a;
  logic [15:0] cnt_a;

  logic        in_ready_b, out_valid_b;
  logic [31:0] inp1_b, inp2_b;
  logic [1:0]  kind_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  alu_operand_stage #(
    .DATA_W(32), .IMM_W(22), .SHAMT_W(5), .IMM_SEXT(1'b1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .rs(rs), .rt(rt), .shamt(shamt), .immt(immt),
    .opcode(opcode), .fcode(fcode),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .inp1(inp1_a), .inp2(inp2_a), .op_kind(kind_a),
    .alu_op_count(cnt_a)
  );

  alu_operand_stage #(
    .DATA_W(32), .IMM_W(22), .SHAMT_W(5), .IMM_SEXT(1'b0), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .rs(rs), .rt(rt), .shamt(shamt), .immt(immt),
    .opcode(opcode), .fcode(fcode),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .inp1(inp1_b), .inp2(inp2_b), .op_kind(kind_b),
    .alu_op_count(cnt_b)
  );

  typedef struct {
    logic [31:0] i1;
    logic [31:0] i2a;
    logic [31:0] i2b;
    logic [1:0]  k;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned mcnt_a = 0;
  int unsigned mcnt_b = 0;
  bit          can_accept = 1'b1;
  bit          after_rst = 1'b0;
  bit          started = 1'b0;
  bit          last_acc = 1'b0;

  function automatic exp_t model();
    exp_t   e;
    longint v;
    e.i1  = 32'd0;
    e.i2a = 32'd0;
    e.i2b = 32'd0;
    e.k   = 2'd0;
    if (opcode == 3'd1) begin
      v = longint'(immt);
      e.i2b = v[31:0];
      if (v >= 2097152) v = v - 4194304;
      e.i2a = v[31:0];
      e.i1  = rs;
      e.k   = 2'd2;
    end else if (opcode == 3'd0) begin
      e.i1 = rs;
      if (fcode < 4'd12) begin
        e.k   = 2'd1;
        e.i2a = rt;
        e.i2b = rt;
      end else begin
        e.k   = 2'd3;
        e.i2a = 32'(shamt);
        e.i2b = 32'(shamt);
      end
    end
    return e;
  endfunction

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  // One clock: the model sees the edge, then new inputs may be driven.
  task automatic cyc();
    @(posedge clk);
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
      mcnt_a    = 0;
      mcnt_b    = 0;
      after_rst = 1'b1;
      started   = 1'b1;
    end else if (in_valid && can_accept) begin
      q.push_back(model());
      after_rst = 1'b0;
      last_acc  = 1'b1;
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] op,
                        input logic [3:0] fc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [4:0] sh,
                        input logic [21:0] im);
    in_valid = v;
    opcode   = op;
    fcode    = fc;
    rs       = r1;
    rt       = r2;
    shamt    = sh;
    immt     = im;
  endtask

  task automatic send_until_acc();
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (last_acc) break;
    end
    if (!last_acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    exp_t e;
    int   n;
    wait (started);
    forever begin
      @(negedge clk);
      n = q.size();
      chk("out_valid_a", 64'(out_valid_a), 64'(n > 0));
      chk("out_valid_b", 64'(out_valid_b), 64'(n > 0));
      chk("in_ready_a", 64'(in_ready_a), 64'(n < 2));
      chk("in_ready_b", 64'(in_ready_b), 64'(n < 2));
      chk("count_a", 64'(cnt_a), 64'(mcnt_a));
      chk("count_b", 64'(cnt_b), 64'(mcnt_b));
      if (n > 0) begin
        chk("inp1_a", 64'(inp1_a), 64'(q[0].i1));
        chk("inp2_a", 64'(inp2_a), 64'(q[0].i2a));
        chk("kind_a", 64'(kind_a), 64'(q[0].k));
        chk("inp1_b", 64'(inp1_b), 64'(q[0].i1));
        chk("inp2_b", 64'(inp2_b), 64'(q[0].i2b));
        chk("kind_b", 64'(kind_b), 64'(q[0].k));
        if (out_ready) begin
          e = q.pop_front();
          if (e.k != 2'd0) begin
            mcnt_a = (mcnt_a + 1) % 65536;
            mcnt_b = (mcnt_b + 1) % 4;
          end
        end
      end else if (after_rst) begin
        chk("rst_inp1", 64'(inp1_a), 64'd0);
        chk("rst_inp2", 64'(inp2_a), 64'd0);
        chk("rst_kind", 64'(kind_a), 64'd0);
      end
      can_accept = (n < 2);
    end
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 3'd1, 4'd0, 32'h77, 32'h0, 5'd0, 22'h1234);
    cyc();
    cyc();
    rst = 1'b0;
    set_in(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 5'd0, 22'h0);
    cyc();
    cyc();

    set_in(1'b1, 3'd1, 4'd0, 32'd5, 32'h0, 5'd0, 22'h3FFFFF);
    cyc();
    set_in(1'b1, 3'd0, 4'd13, 32'd9, 32'hDEAD, 5'd31, 22'h0);
    cyc();
    set_in(1'b1, 3'd0, 4'd11, 32'd9, 32'hDEAD, 5'd31, 22'h0);
    cyc();
    set_in(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 5'd0, 22'h0);
    cyc();
    cyc();

    out_ready = 1'b0;
    set_in(1'b1, 3'd0, 4'd2, 32'hA1, 32'hA2, 5'd1, 22'h0);
    cyc();
    set_in(1'b1, 3'd1, 4'd0, 32'hB1, 32'h0, 5'd0, 22'h200001);
    cyc();
    set_in(1'b1, 3'd0, 4'd15, 32'hC1, 32'hC2, 5'd7, 22'h0);
    cyc();
    cyc();
    cyc();
    out_ready = 1'b1;
    send_until_acc();
    set_in(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 5'd0, 22'h0);
    cyc();
    cyc();
    cyc();

    set_in(1'b1, 3'd3, 4'd1, 32'h55, 32'h66, 5'd3, 22'h7);
    cyc();
    set_in(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 5'd0, 22'h0);
    cyc();
    cyc();

    out_ready = 1'b0;
    set_in(1'b1, 3'd1, 4'd0, 32'h10, 32'h0, 5'd0, 22'h10);
    cyc();
    set_in(1'b1, 3'd1, 4'd0, 32'h20, 32'h0, 5'd0, 22'h20);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_in(1'b1, 3'd0, 4'd3, 32'h30, 32'h31, 5'd0, 22'h0);
    cyc();
    set_in(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 5'd0, 22'h0);
    cyc();
    out_ready = 1'b1;
    cyc();
    cyc();

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 3'd1, 4'd0, 32'(i), 32'h0, 5'd0, 22'(i));
      cyc();
    end
    set_in(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 5'd0, 22'h0);
    cyc();
    cyc();
    @(negedge clk);
    chk("cnt_wrap_b", 64'(cnt_b), 64'd1);
    chk("cnt_five_a", 64'(cnt_a), 64'd5);

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = ($urandom_range(0, 3) == 0) ? 3'($urandom)
                                              : 3'($urandom_range(0, 1));
      fcode     = 4'($urandom);
      rs        = $urandom;
      rt        = $urandom;
      shamt     = 5'($urandom);
      immt      = 22'($urandom);
      cyc();
    end

    rst = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    @(negedge clk);
    chk("drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
